// File: rtl/modport_fifo_pkg.sv
// Shared sizing for the modport_fifo slice. The word width follows the `DATA_WIDTH
// macro when the build provides one, otherwise it is 8 bits.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package modport_fifo_pkg;

  localparam int DEF_DATA_WIDTH = `DATA_WIDTH;
  localparam int DEF_ADDR_WIDTH = 4;

  function automatic int depth_of(input int addr_width);
    return 2 ** addr_width;
  endfunction

  localparam int DEF_DEPTH = depth_of(DEF_ADDR_WIDTH);

endpackage

// File: rtl/modport_fifo_if.sv
// Write/read handshake bundle for modport_fifo. The woverflow/runderflow
// flags exist only when FIFO_OVF_CHK_EN is defined.
interface modport_fifo_if
  import modport_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic                  winc;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wfull;
  logic                  rinc;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rempty;

`ifdef FIFO_OVF_CHK_EN
  logic                  woverflow;
  logic                  runderflow;

  modport master (
    output winc, wdata, rinc,
    input  wfull, rdata, rempty, woverflow, runderflow
  );

  modport slave (
    input  winc, wdata, rinc,
    output wfull, rdata, rempty, woverflow, runderflow
  );
`else
  modport master (
    output winc, wdata, rinc,
    input  wfull, rdata, rempty
  );

  modport slave (
    input  winc, wdata, rinc,
    output wfull, rdata, rempty
  );
`endif

endinterface

// File: rtl/modport_fifo_mem.sv
// DEPTH x DATA_WIDTH storage for modport_fifo: synchronous write port,
// asynchronous read port so the head word can be shown ahead.
module modport_fifo_mem
  import modport_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array is deliberately left out of reset; stale words are never
  // visible because the top masks rdata while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/modport_fifo.sv
// Single-clock show-ahead FIFO with wrap-bit binary pointers. Defining
// FIFO_OVF_CHK_EN adds sticky woverflow/runderflow flags.
module modport_fifo
  import modport_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  modport_fifo_if.slave bus
);

  logic [ADDR_WIDTH:0]   wptr;
  logic [ADDR_WIDTH:0]   rptr;
  logic                  empty;
  logic                  full;
  logic                  do_write;
  logic                  do_read;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Flags come only from registered pointers, so no input reaches an output combinationally.
  assign empty = (wptr == rptr);
  assign full  = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                 (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);

  assign do_write = bus.winc && !full && !rst;
  assign do_read  = bus.rinc && !empty;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_write) wptr <= wptr + 1'b1;
      if (do_read)  rptr <= rptr + 1'b1;
    end
  end

  modport_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (do_write),
    .waddr (wptr[ADDR_WIDTH-1:0]),
    .wdata (bus.wdata),
    .raddr (rptr[ADDR_WIDTH-1:0]),
    .rdata (mem_rdata)
  );

  assign bus.rempty = empty;
  assign bus.wfull  = full;
  assign bus.rdata  = empty ? '0 : mem_rdata;

`ifdef FIFO_OVF_CHK_EN
  logic woverflow_q;
  logic runderflow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      woverflow_q  <= 1'b0;
      runderflow_q <= 1'b0;
    end else begin
      if (bus.winc && full)  woverflow_q  <= 1'b1;
      if (bus.rinc && empty) runderflow_q <= 1'b1;
    end
  end

  assign bus.woverflow  = woverflow_q;
  assign bus.runderflow = runderflow_q;
`endif

endmodule

// File: tb/tb_modport_fifo.sv
// Self-checking bench for modport_fifo: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_modport_fifo;
  import modport_fifo_pkg::*;

  typedef logic [DEF_DATA_WIDTH-1:0] word_t;

  logic clk;
  logic rst;

  modport_fifo_if #(.DATA_WIDTH(DEF_DATA_WIDTH)) bus ();

  modport_fifo #(
    .DATA_WIDTH (DEF_DATA_WIDTH),
    .ADDR_WIDTH (DEF_ADDR_WIDTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    checks;
  int    errors;
  word_t model_q[$];
  bit    model_ovf;
  bit    model_unf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic compare_outputs();
    word_t head;
    head = (model_q.size() != 0) ? model_q[0] : '0;
    check("rempty", 32'(bus.rempty), 32'(model_q.size() == 0));
    check("wfull",  32'(bus.wfull),  32'(model_q.size() == DEF_DEPTH));
    check("rdata",  32'(bus.rdata),  32'(head));
`ifdef FIFO_OVF_CHK_EN
    check("woverflow",  32'(bus.woverflow),  32'(model_ovf));
    check("runderflow", 32'(bus.runderflow), 32'(model_unf));
`endif
  endtask

  // One clock: drive at the falling edge, update the model at the rising edge,
  // compare at the next falling edge.
  task automatic step(input bit r, input bit w, input word_t d, input bit rd);
    bit was_full;
    bit was_empty;
    rst       = r;
    bus.winc  = w;
    bus.wdata = d;
    bus.rinc  = rd;
    @(posedge clk);
    was_full  = (model_q.size() == DEF_DEPTH);
    was_empty = (model_q.size() == 0);
    if (r) begin
      model_q.delete();
      model_ovf = 1'b0;
      model_unf = 1'b0;
    end else begin
      if (w && was_full)   model_ovf = 1'b1;
      if (rd && was_empty) model_unf = 1'b1;
      if (rd && !was_empty) void'(model_q.pop_front());
      if (w && !was_full)   model_q.push_back(d);
    end
    @(negedge clk);
    compare_outputs();
  endtask

  word_t got_stream[$];

  initial begin
    checks    = 0;
    errors    = 0;
    model_ovf = 1'b0;
    model_unf = 1'b0;
    rst       = 1'b1;
    bus.winc  = 1'b0;
    bus.wdata = '0;
    bus.rinc  = 1'b0;

    // Reset with requests asserted; they must be ignored.
    step(1'b1, 1'b1, word_t'(8'h77), 1'b1);
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);

    // Single word in, single word out.
    step(1'b0, 1'b1, word_t'(8'hA5), 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);

    // Fill, overflow attempt, drain, then underflow attempt.
    for (int i = 0; i < DEF_DEPTH; i++) step(1'b0, 1'b1, word_t'(i), 1'b0);
    step(1'b0, 1'b1, word_t'(8'hFF), 1'b0);
    for (int i = 0; i < DEF_DEPTH; i++) step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);

    // Simultaneous requests on a full FIFO, then on an empty FIFO.
    for (int i = 0; i < DEF_DEPTH; i++) step(1'b0, 1'b1, word_t'(8'h40 + i), 1'b0);
    step(1'b0, 1'b1, word_t'(8'hEE), 1'b1);
    for (int i = 0; i < DEF_DEPTH; i++) step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b1, word_t'(8'h5A), 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);

    // Continuous streaming of 1..40 across several pointer wraps.
    got_stream.delete();
    for (int i = 1; i <= 40; i++) begin
      if (!bus.rempty) got_stream.push_back(bus.rdata);
      step(1'b0, 1'b1, word_t'(i), 1'b1);
    end
    for (int n = 0; n < 2 * DEF_DEPTH && !bus.rempty; n++) begin
      got_stream.push_back(bus.rdata);
      step(1'b0, 1'b0, '0, 1'b1);
    end
    check("stream_len", 32'(got_stream.size()), 32'd40);
    for (int i = 0; i < got_stream.size() && i < 40; i++)
      check("stream_word", 32'(got_stream[i]), 32'(i + 1));

    // Reset mid-operation discards contents; FIFO is usable afterwards.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, word_t'(8'h10 + i), 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, word_t'(8'h3C), 1'b0);
    check("post_reset_word", 32'(bus.rdata), 32'h3C);
    step(1'b0, 1'b0, '0, 1'b1);

    // Random traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 99) < 55,
           word_t'($urandom),
           $urandom_range(0, 99) < 50);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
